// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register sequencer.
package usr_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SHR   = 3'd2,
        OP_SHL   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SETTLE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/usr_cmd_sequencer_if.sv
// Command request / response channel between issuer and sequencer.
interface usr_cmd_sequencer_if
    import usr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_cnt, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_cnt, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/usr_step_cnt.sv
// Loadable down-counter that sets the length of the EXEC phase.
module usr_step_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Sequences shift-register commands onto a universal shift register
// and returns the sampled register contents.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             clear_b,
    usr_cmd_sequencer_if.slave bus,
    output logic             usr_s1,
    output logic             usr_s0,
    output logic [WIDTH-1:0] usr_in,
    output logic             usr_msb_in,
    output logic             usr_lsb_in,
    output logic             usr_clr_b,
    input  logic [WIDTH-1:0] usr_out
);

    state_e           state_q, state_d;
    op_e              op_q, op_in;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             rdy_q;
    logic             clr_q;
    logic             accept;
    logic             last;
    logic [CNT_W-1:0] n_steps;
    logic [1:0]       mode;
    logic             cmd_ready_c;
    logic             rsp_valid_c;

    assign op_in  = op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && cmd_ready_c;

    always_comb begin
        n_steps = '0;
        unique case (op_in)
            OP_LOAD, OP_CLEAR:              n_steps = CNT_W'(1);
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: n_steps = bus.cmd_cnt;
            default:                        n_steps = '0;
        endcase
    end

    usr_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
        .clk      (clk),
        .clear_b  (clear_b),
        .load     (accept),
        .load_val (n_steps),
        .dec      (state_q == ST_EXEC),
        .last     (last)
    );

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept)
                    state_d = (n_steps != '0) ? ST_EXEC : ST_SETTLE;
            end
            ST_EXEC:   if (last) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // rdy_q keeps cmd_ready low until the first edge after reset release;
    // clr_q drops on the CLEAR accept edge so it is low only for its EXEC cycle.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            rdy_q      <= 1'b0;
            clr_q      <= 1'b0;
            op_q       <= OP_READ;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            clr_q <= !(accept && op_in == OP_CLEAR);
            if (accept) begin
                op_q   <= op_in;
                data_q <= bus.cmd_data;
            end
            if (state_q == ST_SETTLE) begin
                rsp_data_q <= usr_out;
                rsp_err_q  <= (op_q == OP_RSVD);
            end
        end
    end

    always_comb begin
        mode        = MODE_HOLD;
        usr_in      = '0;
        usr_msb_in  = 1'b0;
        usr_lsb_in  = 1'b0;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        unique case (state_q)
            ST_IDLE: cmd_ready_c = rdy_q;
            ST_EXEC: begin
                unique case (op_q)
                    OP_LOAD: begin
                        mode   = MODE_LOAD;
                        usr_in = data_q;
                    end
                    OP_SHR: begin
                        mode       = MODE_SHR;
                        usr_msb_in = data_q[0];
                    end
                    OP_SHL: begin
                        mode       = MODE_SHL;
                        usr_lsb_in = data_q[0];
                    end
                    OP_ROR: begin
                        mode       = MODE_SHR;
                        usr_msb_in = usr_out[0];
                    end
                    OP_ROL: begin
                        mode       = MODE_SHL;
                        usr_lsb_in = usr_out[WIDTH-1];
                    end
                    default: mode = MODE_HOLD;
                endcase
            end
            ST_SETTLE: mode = MODE_HOLD;
            ST_RESP:   rsp_valid_c = 1'b1;
            default:   mode = MODE_HOLD;
        endcase
    end

    assign {usr_s1, usr_s0} = mode;
    assign usr_clr_b        = clr_q;
    assign bus.cmd_ready    = cmd_ready_c;
    assign bus.rsp_valid    = rsp_valid_c;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer with a behavioural universal shift register.
module tb_usr_cmd_sequencer;

    logic       clk = 1'b0;
    logic       clear_b = 1'b0;
    logic       usr_s1, usr_s0, usr_msb_in, usr_lsb_in, usr_clr_b;
    logic [3:0] usr_in;
    logic [3:0] usr_q;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int act_cyc = 0, match_cyc = 0, clr_cyc = 0;
    logic [1:0] cur_mode = 2'b00;

    typedef struct {
        logic [3:0] data;
        logic       err;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0] op;
        logic [3:0] d;
        logic [2:0] c;
        logic [3:0] ed;
        logic       ee;
        int         lat;
        logic [1:0] md;
        int         act;
        int         clr;
    } vec_t;
    vec_t vt[13];

    usr_cmd_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

    usr_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .clear_b    (clear_b),
        .bus        (bus),
        .usr_s1     (usr_s1),
        .usr_s0     (usr_s0),
        .usr_in     (usr_in),
        .usr_msb_in (usr_msb_in),
        .usr_lsb_in (usr_lsb_in),
        .usr_clr_b  (usr_clr_b),
        .usr_out    (usr_q)
    );

    assign mode = {usr_s1, usr_s0};

    always #5 clk = ~clk;

    // Reference universal shift register with async active-low clear.
    always @(posedge clk or negedge usr_clr_b) begin
        if (!usr_clr_b) usr_q <= 4'b0000;
        else begin
            case (mode)
                2'b01:   usr_q <= {usr_msb_in, usr_q[3:1]};
                2'b10:   usr_q <= {usr_q[2:0], usr_lsb_in};
                2'b11:   usr_q <= usr_in;
                default: usr_q <= usr_q;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mode != 2'b00) act_cyc <= act_cyc + 1;
        if (mode != 2'b00 && mode == cur_mode) match_cyc <= match_cyc + 1;
        if (!usr_clr_b) clr_cyc <= clr_cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input vec_t v, input int hold);
        int t, a, a0, m0, c0;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_data  = v.d;
        bus.cmd_cnt   = v.c;
        cur_mode      = v.md;
        t = 0;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        a = cyc; a0 = act_cyc; m0 = match_cyc; c0 = clr_cyc;
        sb.push_back('{v.ed, v.ee, v.lat});
        @(negedge clk);
        t = 0;
        while (!bus.rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("rsp_data", int'(bus.rsp_data), int'(e.data));
        chk("rsp_err", int'(bus.rsp_err), int'(e.err));
        chk("latency", cyc - a, e.lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_data", int'(bus.rsp_data), int'(e.data));
            chk("hold_valid", int'(bus.rsp_valid), 1);
            chk("hold_busy", int'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("mode_cycles", act_cyc - a0, v.act);
        chk("mode_kind", match_cyc - m0, v.act);
        chk("clr_cycles", clr_cyc - c0, v.clr);
        chk("idle_after", int'(bus.cmd_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, seen;
        vec_t v;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        bus.cmd_cnt   = 3'd0;
        bus.rsp_ready = 1'b0;

        //        op    d        c     ed       ee    lat md     act clr
        vt[0]  = '{3'd1, 4'b1011, 3'd0, 4'b1011, 1'b0, 2, 2'b11, 1, 0};
        vt[1]  = '{3'd2, 4'b0001, 3'd2, 4'b1110, 1'b0, 3, 2'b01, 2, 0};
        vt[2]  = '{3'd1, 4'b1011, 3'd0, 4'b1011, 1'b0, 2, 2'b11, 1, 0};
        vt[3]  = '{3'd5, 4'b0000, 3'd3, 4'b1101, 1'b0, 4, 2'b10, 3, 0};
        vt[4]  = '{3'd0, 4'b1111, 3'd7, 4'b1101, 1'b0, 1, 2'b00, 0, 0};
        vt[5]  = '{3'd3, 4'b0000, 3'd2, 4'b0100, 1'b0, 3, 2'b10, 2, 0};
        vt[6]  = '{3'd4, 4'b0001, 3'd5, 4'b0010, 1'b0, 6, 2'b01, 5, 0};
        vt[7]  = '{3'd2, 4'b0000, 3'd7, 4'b0000, 1'b0, 8, 2'b01, 7, 0};
        vt[8]  = '{3'd1, 4'b0110, 3'd0, 4'b0110, 1'b0, 2, 2'b11, 1, 0};
        vt[9]  = '{3'd6, 4'b1111, 3'd3, 4'b0000, 1'b0, 2, 2'b00, 0, 1};
        vt[10] = '{3'd7, 4'b1111, 3'd5, 4'b0000, 1'b1, 1, 2'b00, 0, 0};
        vt[11] = '{3'd3, 4'b0001, 3'd7, 4'b1111, 1'b0, 8, 2'b10, 7, 0};
        vt[12] = '{3'd5, 4'b0000, 3'd0, 4'b1111, 1'b0, 1, 2'b00, 0, 0};

        // Reset state, then release.
        #12;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_rsp_err", int'(bus.rsp_err), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_usr_clr_b", int'(usr_clr_b), 0);
        @(negedge clk);
        clear_b = 1'b1;
        #1;
        chk("rel_pre_ready", int'(bus.cmd_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rel_usr_clr_b", int'(usr_clr_b), 1);
        chk("rel_usr_out", int'(usr_q), 0);

        foreach (vt[i]) do_cmd(vt[i], 0);

        // Backpressure: response held for three cycles.
        v = '{3'd0, 4'b0000, 3'd0, 4'b1111, 1'b0, 1, 2'b00, 0, 0};
        do_cmd(v, 3);

        // Response handshake with a command waiting: only the response goes.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        @(posedge clk);
        #1;
        chk("simul_accept_read", int'(bus.cmd_ready), 0);
        bus.cmd_op   = 3'd1;
        bus.cmd_data = 4'b0101;
        t = 0;
        @(negedge clk);
        while (!bus.rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("simul_rsp", int'(bus.rsp_data), 4'b1111);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("simul_only_rsp", int'(bus.cmd_ready), 1);
        chk("simul_no_mode", int'(mode), 0);
        bus.cmd_valid = 1'b0;
        v = '{3'd1, 4'b0101, 3'd0, 4'b0101, 1'b0, 2, 2'b11, 1, 0};
        do_cmd(v, 0);

        // Reset during EXEC of SHL cnt=7.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_data  = 4'b0001;
        bus.cmd_cnt   = 3'd7;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("exec_mode", int'(mode), 2);
        clear_b = 1'b0;
        #1;
        chk("mid_rst_ready", int'(bus.cmd_ready), 0);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_valid", int'(bus.rsp_valid), 0);
        chk("mid_rst_usr_out", int'(usr_q), 0);
        @(negedge clk);
        clear_b = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", int'(bus.cmd_ready), 1);
        chk("mid_rel_clr_b", int'(usr_clr_b), 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        chk("sb_empty", sb.size(), 0);
        v = '{3'd0, 4'b0000, 3'd0, 4'b0000, 1'b0, 1, 2'b00, 0, 0};
        do_cmd(v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_cmd_sequencer.md
# usr_cmd_sequencer

Command-driven controller for the 4-bit universal shift register. It accepts shift-register commands over a valid/ready request channel and drives the register's mode-select, parallel, and serial inputs for the required number of cycles. It then samples the register output and returns the result over a valid/ready response channel. It sits between the command issuer and the universal shift register, acting as the initiator for the register's control interface.

## Interface
- WIDTH, 4, register width; `usr_in`, `usr_out`, `cmd_data` and `rsp_data` are WIDTH bits.
- CNT_W, 3, width of the shift-count field; maximum count is 2^CNT_W-1.

- clk  in  1  system clock, rising edge.
- clear_b  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 READ, 1 LOAD, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6 CLEAR, 7 reserved.
- cmd_data  in  WIDTH  LOAD value; bit 0 is the fill bit for SHR and SHL.
- cmd_cnt  in  CNT_W  number of shift cycles for opcodes 2–5.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  sampled register contents.
- rsp_err  out  1  reserved opcode received.
- usr_s1, usr_s0  out  1 each  register mode: 00 hold, 01 shift right (MSB_in enters bit WIDTH-1), 10 shift left (LSB_in enters bit 0), 11 parallel load.
- usr_in  out  WIDTH  register parallel input.
- usr_msb_in, usr_lsb_in  out  1 each  register serial inputs.
- usr_clr_b  out  1  register clear, active-low, driven from a flop.
- usr_out  in  WIDTH  register output.

## Operation
- State machine states: IDLE, EXEC, SETTLE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - A command is accepted on the edge where `cmd_valid` and `cmd_ready` are both 1; `cmd_op`, `cmd_data` and `cmd_cnt` are latched on that edge.
  - Step count N: LOAD 1; CLEAR 1; SHR/SHL/ROR/ROL use `cmd_cnt`; READ and reserved use 0.
  - If N>0 → EXEC; if N=0 → SETTLE.
- EXEC:
  - Lasts exactly N cycles, counted down by a step counter.
  - LOAD: mode 11, `usr_in`=`cmd_data`.
  - SHR: mode 01, `usr_msb_in`=`cmd_data[0]`.
  - SHL: mode 10, `usr_lsb_in`=`cmd_data[0]`.
  - ROR: mode 01, `usr_msb_in`=`usr_out[0]` (combinational).
  - ROL: mode 10, `usr_lsb_in`=`usr_out[WIDTH-1]` (combinational).
  - CLEAR: mode 00, `usr_clr_b` flop low for exactly this one cycle.
  - After the last EXEC cycle → SETTLE.
- SETTLE:
  - Mode 00 (hold).
  - At the end-of-cycle edge, capture `rsp_data`=`usr_out`; set `rsp_err`=1 if the opcode was 7, else 0.
  - → RESP.
- RESP:
  - `rsp_valid`=1; mode 00.
  - `rsp_data` and `rsp_err` are held stable until `rsp_ready`=1.
  - On the handshake edge → IDLE.
- Outside EXEC: mode 00, `usr_in`=0, `usr_msb_in`=0, `usr_lsb_in`=0.
- Counts greater than WIDTH are legal: shifts simply continue for the full count (fill saturates, rotates wrap).

## Timing
- Reset values while `clear_b`=0:
  - state IDLE; `cmd_ready`=0; `rsp_valid`=0; `rsp_data`=0; `rsp_err`=0.
  - mode 00; `usr_in`=0; `usr_msb_in`=0; `usr_lsb_in`=0.
  - `usr_clr_b`=0, so the register is cleared together with the sequencer.
- Reset release: the first posedge after `clear_b` rises sets `cmd_ready`=1 and `usr_clr_b`=1.
- Latency: `rsp_valid` rises N+1 cycles after the accept edge (READ: 1 cycle; LOAD: 2 cycles).
- Throughput:
  - `cmd_ready`=0 in EXEC, SETTLE and RESP.
  - The next command is accepted no earlier than 1 cycle after the response handshake.
  - A simultaneous `rsp_ready` and `cmd_valid` accepts only the response.
- `cmd_valid` while busy: the command is ignored and must be held by the issuer.
- Reset mid-operation: the state machine returns immediately (asynchronously) to IDLE; the in-flight command is dropped with no response; the mode goes to hold.
- `usr_clr_b` is glitch-free: it changes only on a clk edge, apart from the asynchronous reset assertion.

## Structure
- Package `usr_pkg`:
  - opcode enum;
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - state enum;
  - default WIDTH and CNT_W.
- Sub-module `usr_step_cnt`: a loadable CNT_W down-counter with `load`, `dec`, and a `last` flag; it sets the EXEC length.
- Top level holds the state machine, the command latch, the output decode, the `usr_clr_b` flop, and the response register.

## Test plan
All scenarios run with the 4-bit universal shift register attached.
- Reset: assert `clear_b`, then release → `cmd_ready` 0→1 on the first edge; mode 00; `usr_clr_b`=1; `rsp_valid`=0; `usr_out`=0000.
- LOAD `cmd_data`=1011 → mode 11 for exactly 1 cycle with `usr_in`=1011; `rsp_valid` 2 cycles after accept; `rsp_data`=1011; `rsp_err`=0.
- SHR cnt=2 fill=1 from 1011 → mode 01 for 2 cycles; `rsp_data`=1110, 3 cycles after accept.
- ROL cnt=3 from 1011 → register sequence 0111, 1110, 1101; `rsp_data`=1101.
- CLEAR, then op 7:
  - CLEAR → `usr_clr_b` low exactly 1 cycle; `rsp_data`=0000.
  - op 7 → no mode activity; `rsp_err`=1; `rsp_data`=0000.
- Backpressure and reset:
  - `rsp_ready` held low for 3 cycles → `rsp_data` stable and `cmd_ready`=0 throughout.
  - `clear_b` asserted during EXEC of SHL cnt=7 → immediate IDLE, no response; `cmd_ready`=1 after release.
